// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit sitting beside the execute stage.
// Iterative shift-add multiply and restoring divide, UNROLL bits per cycle, with divide fast paths.
module ex_mdu #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic            hold_flag_o,
  output logic            busy_o
);
  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  logic            is_m, start, in_div, sa, sb, div_zero, div_ovf, fast;
  logic [2:0]      f3;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;
  logic            unused_inst;

  assign f3          = inst_i[14:12];
  assign is_m        = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
  assign start       = rst_n && (state == IDLE) && is_m && !flush_i;
  assign in_div      = f3[2];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  // Operand signedness: MUL low half is sign-agnostic, so it runs unsigned.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (f3)
      3'b001, 3'b100, 3'b110: begin
        sa = op1_i[XLEN-1];
        sb = op2_i[XLEN-1];
      end
      3'b010:  sa = op1_i[XLEN-1];
      default: ;
    endcase
  end

  assign abs_a    = neg_x(op1_i, sa);
  assign abs_b    = neg_x(op2_i, sb);
  assign div_zero = in_div && (op2_i == '0);
  assign div_ovf  = in_div && !f3[0] && (op1_i == MIN_NEG) && (op2_i == ALL_ONES);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (f3[1] ? op1_i : ALL_ONES) : (f3[1] ? '0 : MIN_NEG);

  logic [2:0]        f3_r;
  logic              sa_r, sb_r, wen_r;
  logic [4:0]        addr_r;
  logic [2*XLEN-1:0] acc, sh;
  logic [XLEN-1:0]   qv, den, res;

  // Iteration step: both engines evaluated, the latched funct3 picks which one commits.
  logic [2*XLEN-1:0] m_acc, m_sh;
  logic [XLEN-1:0]   m_q, d_q, d_r;
  logic [XLEN:0]     d_t;

  always_comb begin
    m_acc = acc;
    m_sh  = sh;
    m_q   = qv;
    d_q   = qv;
    d_r   = acc[XLEN-1:0];
    d_t   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (m_q[0]) m_acc = m_acc + m_sh;
      m_sh = m_sh << 1;
      m_q  = m_q >> 1;
      d_t  = {d_r, d_q[XLEN-1]};
      d_q  = d_q << 1;
      if (d_t >= {1'b0, den}) begin
        d_t    = d_t - {1'b0, den};
        d_q[0] = 1'b1;
      end
      d_r = d_t[XLEN-1:0];
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    prod = neg_2x(m_acc, sa_r ^ sb_r);
    if (f3_r[2])
      calc_res = f3_r[1] ? neg_x(d_r, sa_r) : neg_x(d_q, sa_r ^ sb_r);
    else
      calc_res = (f3_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CALC && state_nxt == CALC) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = fast ? DONE : CALC;
      CALC: begin
        if (flush_i)              state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at start, iteration in CALC, result latched on the last step.
  always_ff @(posedge clk) begin
    if (start) begin
      f3_r   <= f3;
      sa_r   <= sa;
      sb_r   <= sb;
      addr_r <= rd_addr_i;
      wen_r  <= rd_wen_i;
      acc    <= '0;
      den    <= abs_b;
      res    <= fast_res;
      if (in_div) begin
        sh <= '0;
        qv <= abs_a;
      end else begin
        sh <= {{XLEN{1'b0}}, abs_a};
        qv <= abs_b;
      end
    end else if (state == CALC) begin
      acc <= f3_r[2] ? {{XLEN{1'b0}}, d_r} : m_acc;
      sh  <= m_sh;
      qv  <= f3_r[2] ? d_q : m_q;
      if (cnt == CNT_LAST) res <= calc_res;
    end
  end

  always_comb begin
    rd_wen_o    = 1'b0;
    rd_addr_o   = '0;
    rd_data_o   = '0;
    hold_flag_o = start || (state == CALC);
    busy_o      = (state != IDLE);
    if (state == DONE) begin
      rd_wen_o  = wen_r && !flush_i;
      rd_addr_o = addr_r;
      rd_data_o = res;
    end
  end
endmodule
